// File: rtl/image_test_ctrl.sv
// Frame-synchronous sequencer for the test-pattern injector.
// Gates injection and pattern mode on frame boundaries only.
module image_test_ctrl #(
  parameter int FRAME_W = 8,
  parameter int LINE_W  = 12,
  parameter int MODE_W  = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [FRAME_W-1:0]   i_num_frames,
  input  logic [2**MODE_W-1:0] i_mode_mask,
  input  logic [LINE_W-1:0]    i_exp_lines,
  input  logic                 i_hs,
  input  logic                 i_vs,
  output logic                 o_en,
  output logic [MODE_W-1:0]    o_mode,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_aborted,
  output logic [FRAME_W-1:0]   o_frame_idx,
  output logic                 o_geom_err
);

  localparam int NM = 2**MODE_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic [1:0]         state;
  logic               vs_d;
  logic               hs_d;
  logic [LINE_W-1:0]  line_cnt;
  logic [FRAME_W-1:0] num_q;
  logic [NM-1:0]      mask_q;
  logic [LINE_W-1:0]  exp_q;
  logic               abort_pend;

  logic vs_rise;
  logic vs_fall;
  logic hs_rise;
  logic last_frame;
  logic stop_now;

  function automatic logic [MODE_W-1:0] low_bit(
    input logic [NM-1:0] m
  );
    logic [MODE_W-1:0] r;
    r = '0;
    for (int i = NM-1; i >= 0; i--)
      if (m[i]) r = MODE_W'(i);
    return r;
  endfunction

  // Next set bit above cur, else wrap to the lowest set bit.
  function automatic logic [MODE_W-1:0] next_mode(
    input logic [NM-1:0]     m,
    input logic [MODE_W-1:0] cur
  );
    logic [MODE_W-1:0] r;
    r = low_bit(m);
    for (int i = NM-1; i >= 0; i--)
      if (m[i] && (i > int'(cur))) r = MODE_W'(i);
    return r;
  endfunction

  always_comb begin
    vs_rise    = i_vs & ~vs_d;
    vs_fall    = ~i_vs & vs_d;
    hs_rise    = i_hs & ~hs_d & i_vs;
    last_frame = (num_q != '0) &&
                 ((o_frame_idx + FRAME_W'(1)) == num_q);
    stop_now   = last_frame | abort_pend | i_abort;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      vs_d        <= 1'b0;
      hs_d        <= 1'b0;
      line_cnt    <= '0;
      num_q       <= '0;
      mask_q      <= '0;
      exp_q       <= '0;
      abort_pend  <= 1'b0;
      o_en        <= 1'b0;
      o_mode      <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_aborted   <= 1'b0;
      o_frame_idx <= '0;
      o_geom_err  <= 1'b0;
    end else begin
      vs_d   <= i_vs;
      hs_d   <= i_hs;
      o_done <= 1'b0;

      if (vs_rise)
        line_cnt <= '0;
      else if (hs_rise && (line_cnt != '1))
        line_cnt <= line_cnt + LINE_W'(1);

      case (state)
        S_IDLE: begin
          if (i_start && !i_abort && (|i_mode_mask)) begin
            num_q       <= i_num_frames;
            mask_q      <= i_mode_mask;
            exp_q       <= i_exp_lines;
            abort_pend  <= 1'b0;
            o_frame_idx <= '0;
            o_geom_err  <= 1'b0;
            o_aborted   <= 1'b0;
            o_mode      <= low_bit(i_mode_mask);
            o_busy      <= 1'b1;
            state       <= S_ARM;
          end
        end
        S_ARM: begin
          if (i_abort) begin
            o_busy    <= 1'b0;
            o_done    <= 1'b1;
            o_aborted <= 1'b1;
            state     <= S_IDLE;
          end else if (vs_rise) begin
            o_en  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (i_abort) abort_pend <= 1'b1;
          if (vs_fall) begin
            if (line_cnt != exp_q) o_geom_err <= 1'b1;
            o_frame_idx <= o_frame_idx + FRAME_W'(1);
            if (stop_now) begin
              o_en       <= 1'b0;
              o_busy     <= 1'b0;
              o_done     <= 1'b1;
              o_aborted  <= abort_pend | i_abort;
              abort_pend <= 1'b0;
              state      <= S_IDLE;
            end else begin
              o_mode <= next_mode(mask_q, o_mode);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_image_test_ctrl.sv
// Scoreboard bench for image_test_ctrl: stimulus pushes expected
// done/mode events, a negedge monitor pops and compares them.
module tb_image_test_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] num_frames;
  logic [3:0] mode_mask;
  logic [11:0] exp_lines;
  logic       hs;
  logic       vs;
  logic       en;
  logic [1:0] mode;
  logic       busy;
  logic       done;
  logic       aborted;
  logic [7:0] frame_idx;
  logic       geom_err;

  int n_chk = 0;
  int n_pass = 0;

  logic [13:0] done_q[$];
  logic [1:0]  mode_q[$];

  image_test_ctrl dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_abort      (abort),
    .i_num_frames (num_frames),
    .i_mode_mask  (mode_mask),
    .i_exp_lines  (exp_lines),
    .i_hs         (hs),
    .i_vs         (vs),
    .o_en         (en),
    .o_mode       (mode),
    .o_busy       (busy),
    .o_done       (done),
    .o_aborted    (aborted),
    .o_frame_idx  (frame_idx),
    .o_geom_err   (geom_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic fail(input string nm);
    n_chk++;
    $display("FAIL %s: event with empty scoreboard", nm);
  endtask

  // {en, busy, aborted, frame_idx, geom_err, mode} at the done pulse
  function automatic void exp_done(input logic ab, input logic [7:0] idx,
                                   input logic ge, input logic [1:0] md);
    done_q.push_back({1'b0, 1'b0, ab, idx, ge, md});
  endfunction

  logic       en_p = 1'b0;
  logic [7:0] idx_p = 8'd0;
  logic       vs_p1 = 1'b0;
  logic       vs_p2 = 1'b0;

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (done_q.size() == 0) fail("done_unexp");
      else chk("done", {en, busy, aborted, frame_idx, geom_err, mode},
               done_q.pop_front());
    end
    if (en === 1'b1 && en_p == 1'b0) begin
      if (mode_q.size() == 0) fail("en_unexp");
      else begin
        chk("en_mode", mode, mode_q.pop_front());
        chk("en_timing", {vs_p2, vs_p1}, 2'b01);
      end
    end
    if (en === 1'b1 && busy === 1'b1 && frame_idx != idx_p) begin
      if (mode_q.size() == 0) fail("frame_unexp");
      else chk("frame_mode", mode, mode_q.pop_front());
    end
    en_p  = (en === 1'b1);
    idx_p = frame_idx;
    vs_p2 = vs_p1;
    vs_p1 = vs;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic line();
    hs = 1'b1; tick(); tick();
    hs = 1'b0; tick(); tick();
  endtask

  task automatic frame(input int lines);
    vs = 1'b1; tick();
    for (int i = 0; i < lines; i++) line();
    vs = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic go(input logic [7:0] n, input logic [3:0] m,
                    input logic [11:0] e, input logic ab);
    num_frames = n; mode_mask = m; exp_lines = e;
    start = 1'b1; abort = ab;
    tick();
    start = 1'b0; abort = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    num_frames = '0; mode_mask = '0; exp_lines = '0;
    hs = 1'b0; vs = 1'b0;
    tick(); tick();
    chk("reset", {en, mode, busy, done, aborted, frame_idx, geom_err}, 0);
    rst_n = 1'b1;
    tick();

    // Three single-mode frames, then one frame that must not inject
    for (int i = 0; i < 3; i++) mode_q.push_back(2'd0);
    exp_done(1'b0, 8'd3, 1'b0, 2'd0);
    go(8'd3, 4'b0001, 12'd4, 1'b0);
    chk("busy_arm", {busy, en}, 2'b10);
    frame(4);
    chk("idx1", frame_idx, 8'd1);
    frame(4);
    frame(4);
    frame(4);
    chk("idx_hold", frame_idx, 8'd3);

    // Start mid-frame: remainder of that frame is skipped
    vs = 1'b1; tick(); tick();
    mode_q.push_back(2'd0);
    exp_done(1'b0, 8'd1, 1'b0, 2'd0);
    go(8'd1, 4'b0001, 12'd2, 1'b0);
    line(); line();
    chk("skip_frame", en, 1'b0);
    vs = 1'b0; tick(); tick();
    frame(2);

    // Two-mode round robin, start while busy ignored
    mode_q.push_back(2'd1);
    mode_q.push_back(2'd3);
    mode_q.push_back(2'd1);
    mode_q.push_back(2'd3);
    mode_q.push_back(2'd1);
    exp_done(1'b0, 8'd5, 1'b0, 2'd1);
    go(8'd5, 4'b1010, 12'd3, 1'b0);
    frame(3);
    vs = 1'b1; tick();
    line();
    go(8'd1, 4'b0001, 12'd3, 1'b0);
    line(); line();
    vs = 1'b0; tick(); tick(); tick();
    frame(3); frame(3); frame(3);

    // Continuous, abort during second frame
    mode_q.push_back(2'd0);
    mode_q.push_back(2'd0);
    exp_done(1'b1, 8'd2, 1'b0, 2'd0);
    go(8'd0, 4'b0001, 12'd2, 1'b0);
    frame(2);
    vs = 1'b1; tick();
    line();
    abort = 1'b1; tick(); abort = 1'b0;
    chk("en_after_abort", en, 1'b1);
    abort = 1'b1; tick(); abort = 1'b0;
    line();
    vs = 1'b0; tick(); tick(); tick();
    chk("aborted_held", aborted, 1'b1);

    // Abort in ARM: immediate done, no injection
    exp_done(1'b1, 8'd0, 1'b0, 2'd2);
    go(8'd2, 4'b0100, 12'd2, 1'b0);
    abort = 1'b1; tick(); abort = 1'b0;
    frame(2);

    // Geometry error on the third frame
    mode_q.push_back(2'd0);
    mode_q.push_back(2'd1);
    mode_q.push_back(2'd0);
    mode_q.push_back(2'd1);
    exp_done(1'b0, 8'd4, 1'b1, 2'd1);
    go(8'd4, 4'b0011, 12'd4, 1'b0);
    frame(4); frame(4);
    chk("geom_before", geom_err, 1'b0);
    frame(5);
    chk("geom_set", geom_err, 1'b1);
    frame(4);

    // Ignored starts
    go(8'd1, 4'b0001, 12'd2, 1'b1);
    chk("start_abort", busy, 1'b0);
    go(8'd1, 4'b0000, 12'd2, 1'b0);
    chk("mask_zero", busy, 1'b0);
    chk("geom_sticky", geom_err, 1'b1);

    // Reset in RUN: drop en/busy, no done
    mode_q.push_back(2'd0);
    go(8'd0, 4'b0001, 12'd2, 1'b0);
    chk("geom_clear", {busy, geom_err}, 2'b10);
    vs = 1'b1; tick();
    line();
    rst_n = 1'b0; tick();
    chk("rst_run", {en, busy, done}, 3'b000);
    rst_n = 1'b1;
    line();
    vs = 1'b0; tick(); tick(); tick();
    frame(2);

    chk("done_q_empty", done_q.size(), 0);
    chk("mode_q_empty", mode_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
